// File: rtl/trap_controller.sv
// Machine-mode trap sequencer and trap CSR file (mstatus, mtvec, mepc, mcause, optional mtval via MTVAL_EN).
// Latency: exception sampled at T -> flush T+1, CSR save T+2, redirect T+3; mret sampled at T -> redirect T+1.
// Backpressure: trap/mret sampled only in IDLE with i_stall low; o_busy holds the front end while sequencing.
module trap_controller #(
  parameter logic [1:0]  RESET_PRIV  = 2'b11,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_exception,
  input  logic [3:0]  i_cause,
  input  logic        i_mret,
  input  logic [31:0] i_PC,
  input  logic [31:0] i_inst,
  input  logic        i_stall,
  input  logic        i_csrWe,
  input  logic [11:0] i_csrAddr,
  input  logic [31:0] i_csrWdata,
  output logic [31:0] o_csrRdata,
  output logic [1:0]  o_privMode,
  output logic        o_busy,
  output logic        o_flush,
  output logic        o_redirect,
  output logic [31:0] o_redirectPC
);

  typedef enum logic [2:0] {IDLE, FLUSH, SAVE, REDIRECT, RET} trapState_t;

  trapState_t state, nextState;

  // Latched trap context, captured when the exception is accepted.
  logic [31:0] latPC;
  logic [3:0]  latCause;
  logic [1:0]  latPriv;

  // Architectural state. Low bits of mtvec/mepc are always zero, so not stored.
  logic [1:0]  privMode;
  logic        mie, mpie;
  logic [1:0]  mpp;
  logic [31:2] mtvec;
  logic [31:2] mepc;
  logic [31:0] mcause;

  logic acceptTrap, acceptRet;
  assign acceptTrap = (state == IDLE) && !i_stall && i_exception;
  assign acceptRet  = (state == IDLE) && !i_stall && !i_exception && i_mret;

`ifdef MTVAL_EN
  logic [31:0] latInst;
  logic [31:0] mtval;
  logic [31:0] mtvalNext;

  // Fault-specific mtval value: faulting PC for fetch faults, instruction word for illegal instruction.
  always_comb begin
    mtvalNext = 32'h0;
    case (latCause)
      4'd0, 4'd1: mtvalNext = latPC;
      4'd2:       mtvalNext = latInst;
      default:    mtvalNext = 32'h0;
    endcase
  end
`else
  // Instruction word and low PC bits only feed mtval, which is absent in this build.
  logic unusedBits;
  assign unusedBits = ^{i_inst, latPC[1:0]};
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state decode and sequence strobes.
  always_comb begin
    nextState    = state;
    o_flush      = 1'b0;
    o_redirect   = 1'b0;
    o_redirectPC = 32'h0;
    case (state)
      IDLE: begin
        if (acceptTrap)     nextState = FLUSH;
        else if (acceptRet) nextState = RET;
      end
      FLUSH: begin
        o_flush   = 1'b1;
        nextState = SAVE;
      end
      SAVE: nextState = REDIRECT;
      REDIRECT: begin
        o_redirect   = 1'b1;
        o_redirectPC = {mtvec, 2'b00};
        nextState    = IDLE;
      end
      RET: begin
        o_redirect   = 1'b1;
        o_redirectPC = {mepc, 2'b00};
        nextState    = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign o_busy     = (state != IDLE);
  assign o_privMode = privMode;

  // Trap context capture, software CSR writes, then hardware updates (later assignment wins a conflict).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      latPC    <= 32'h0;
      latCause <= 4'h0;
      latPriv  <= 2'b00;
      privMode <= RESET_PRIV;
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mpp      <= 2'b00;
      mtvec    <= MTVEC_RESET[31:2];
      mepc     <= 30'h0;
      mcause   <= 32'h0;
`ifdef MTVAL_EN
      latInst  <= 32'h0;
      mtval    <= 32'h0;
`endif
    end else begin
      if (acceptTrap) begin
        latPC    <= i_PC;
        latCause <= i_cause;
        latPriv  <= privMode;
`ifdef MTVAL_EN
        latInst  <= i_inst;
`endif
      end
      if (i_csrWe) begin
        case (i_csrAddr)
          12'h300: begin
            mie  <= i_csrWdata[3];
            mpie <= i_csrWdata[7];
            mpp  <= i_csrWdata[12:11];
          end
          12'h305: mtvec  <= i_csrWdata[31:2];
          12'h341: mepc   <= i_csrWdata[31:2];
          12'h342: mcause <= i_csrWdata;
`ifdef MTVAL_EN
          12'h343: mtval  <= i_csrWdata;
`endif
          default: ;
        endcase
      end
      if (state == SAVE) begin
        mepc     <= latPC[31:2];
        mcause   <= {28'h0, latCause};
        mpp      <= latPriv;
        mpie     <= mie;
        mie      <= 1'b0;
        privMode <= 2'b11;
`ifdef MTVAL_EN
        mtval    <= mtvalNext;
`endif
      end
      if (state == RET) begin
        privMode <= mpp;
        mpp      <= 2'b00;
        mie      <= mpie;
        mpie     <= 1'b1;
      end
    end
  end

  // Combinational CSR read of current state; unimplemented addresses read zero.
  always_comb begin
    o_csrRdata = 32'h0;
    case (i_csrAddr)
      12'h300: o_csrRdata = {19'h0, mpp, 3'b000, mpie, 3'b000, mie, 3'b000};
      12'h305: o_csrRdata = {mtvec, 2'b00};
      12'h341: o_csrRdata = {mepc, 2'b00};
      12'h342: o_csrRdata = mcause;
`ifdef MTVAL_EN
      12'h343: o_csrRdata = mtval;
`endif
      default: o_csrRdata = 32'h0;
    endcase
  end

endmodule
